hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32 core. Watches the decode-stage operands and the EX/MEM/WB destination fields, then drives the stall and flush controls of the IF/ID and ID/EX registers. It also selects the operand-forwarding sources.

---
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage RV32 core.
// Generates IF/ID and ID/EX stall/flush controls for load-use bubbles,
// post-redirect flushes and CSR drain serialization, and picks the
// operand forwarding sources for the decode stage.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_csr,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_redirect,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    REDIRECT  = 2'b01,
    DRAIN     = 2'b10,
    LOADSTALL = 2'b11
  } state_t;

  // Counter reload values: the triggering cycle itself is the first
  // flush/stall cycle, so the counter covers the remaining ones.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [2:0]       r_cnt;
  logic [2:0]       w_nextCnt;
  logic             r_csrOk;
  logic             w_nextCsrOk;
  logic [CNT_W-1:0] r_stallCnt;

  logic             w_lu;
  logic             w_csrTrig;
  logic             w_stall;
  logic             w_flush;
  logic [1:0]       w_fwdA;
  logic [1:0]       w_fwdB;

  // Hazard detection: load-use against EX, CSR needs older writers drained
  always_comb begin
    w_lu = ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) ||
            (id_use_rs2 && (id_rs2 == ex_rd)));
    w_csrTrig = id_csr && !r_csrOk && !w_lu &&
                (ex_reg_write || mem_reg_write || wb_reg_write);
  end

  // Next-state and stall/flush decode; redirect outranks everything
  always_comb begin
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextCsrOk = r_csrOk;
    if (ex_redirect) begin
      w_flush     = 1'b1;
      w_nextCsrOk = 1'b0;
      if (FLUSH_LOAD == 3'd0) begin
        w_nextState = RUN;
        w_nextCnt   = 3'd0;
      end else begin
        w_nextState = REDIRECT;
        w_nextCnt   = FLUSH_LOAD;
      end
    end else begin
      case (r_state)
        REDIRECT: begin
          w_flush = 1'b1;
          if (r_cnt <= 3'd1) begin
            w_nextState = RUN;
            w_nextCnt   = 3'd0;
          end else begin
            w_nextCnt = r_cnt - 3'd1;
          end
        end
        DRAIN: begin
          w_stall = 1'b1;
          if (r_cnt <= 3'd1) begin
            w_nextState = RUN;
            w_nextCnt   = 3'd0;
            w_nextCsrOk = 1'b1;
          end else begin
            w_nextCnt = r_cnt - 3'd1;
          end
        end
        default: begin
          if (w_lu) begin
            w_stall     = 1'b1;
            w_nextState = LOADSTALL;
          end else if (w_csrTrig) begin
            w_stall = 1'b1;
            if (DRAIN_LOAD == 3'd0) begin
              w_nextState = RUN;
              w_nextCnt   = 3'd0;
              w_nextCsrOk = 1'b1;
            end else begin
              w_nextState = DRAIN;
              w_nextCnt   = DRAIN_LOAD;
            end
          end else begin
            w_nextState = RUN;
            w_nextCsrOk = 1'b0;
          end
        end
      endcase
    end
  end

  // Operand forwarding: MEM beats WB, x0 is never forwarded
  always_comb begin
    w_fwdA = 2'b00;
    w_fwdB = 2'b00;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == id_rs1)) begin
      w_fwdA = 2'b01;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1)) begin
      w_fwdA = 2'b10;
    end
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == id_rs2)) begin
      w_fwdB = 2'b01;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2)) begin
      w_fwdB = 2'b10;
    end
  end

  // State, down-counter, CSR permission and stall counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_cnt      <= 3'd0;
      r_csrOk    <= 1'b0;
      r_stallCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_csrOk    <= w_nextCsrOk;
      r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, w_stall};
    end
  end

  // Outputs are forced quiet while reset is held
  always_comb begin
    stall_if  = !reset && w_stall;
    stall_id  = !reset && w_stall;
    flush_id  = !reset && w_flush;
    flush_ex  = !reset && (w_flush || w_stall);
    fwd_a     = reset ? 2'b00 : w_fwdA;
    fwd_b     = reset ? 2'b00 : w_fwdB;
    state     = reset ? 2'b00 : r_state;
    stall_cnt = r_stallCnt;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. The driver issues one
// stimulus per cycle and pushes the reference model's expected outputs;
// a monitor pops and compares them mid-cycle.
module tb_hazard_ctrl;

  localparam int FLUSH_N = 2;
  localparam int DRAIN_N = 3;
  localparam int CW      = 32;

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_csr;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_reg_write;
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    logic [4:0] wb_rd;
    logic       wb_reg_write;
    logic       ex_redirect;
  } stim_t;

  typedef struct packed {
    logic          stall_if;
    logic          stall_id;
    logic          flush_id;
    logic          flush_ex;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
  logic          id_use_rs1 = 0, id_use_rs2 = 0, id_csr = 0;
  logic          ex_mem_read = 0, ex_reg_write = 0, mem_reg_write = 0;
  logic          wb_reg_write = 0, ex_redirect = 0;
  logic          stall_if, stall_id, flush_id, flush_ex;
  logic [1:0]    fwd_a, fwd_b, state;
  logic [CW-1:0] stall_cnt;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: remaining-cycle budgets rather than a state machine
  int            flushLeft = 0;
  int            drainLeft = 0;
  bit            inLoadStall = 0;
  bit            csrOk = 0;
  logic [CW-1:0] modelCnt = '0;

  hazard_ctrl #(.FLUSH_CYCLES(FLUSH_N), .DRAIN_CYCLES(DRAIN_N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_csr(id_csr),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_redirect(ex_redirect),
    .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] fwdRef(input logic [4:0] rs, input stim_t s);
    if (s.mem_reg_write && s.mem_rd != 0 && s.mem_rd == rs) return 2'b01;
    if (s.wb_reg_write && s.wb_rd != 0 && s.wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.id_rs1        = 5'($urandom_range(0, 3));
    s.id_rs2        = 5'($urandom_range(0, 3));
    s.id_use_rs1    = 1'($urandom_range(0, 1));
    s.id_use_rs2    = 1'($urandom_range(0, 1));
    s.id_csr        = ($urandom_range(0, 9) < 3);
    s.ex_rd         = 5'($urandom_range(0, 3));
    s.ex_mem_read   = ($urandom_range(0, 9) < 4);
    s.ex_reg_write  = 1'($urandom_range(0, 1));
    s.mem_rd        = 5'($urandom_range(0, 3));
    s.mem_reg_write = 1'($urandom_range(0, 1));
    s.wb_rd         = 5'($urandom_range(0, 3));
    s.wb_reg_write  = 1'($urandom_range(0, 1));
    s.ex_redirect   = ($urandom_range(0, 19) == 0);
    return s;
  endfunction

  // Expected outputs for this cycle, then advance the model past the edge
  task automatic modelStep(input stim_t s, output exp_t e);
    bit lu;
    bit anyWrite;
    e = '0;
    lu = s.ex_mem_read && s.ex_reg_write && s.ex_rd != 0 &&
         ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) ||
          (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
    anyWrite = s.ex_reg_write || s.mem_reg_write || s.wb_reg_write;
    e.fwd_a = fwdRef(s.id_rs1, s);
    e.fwd_b = fwdRef(s.id_rs2, s);
    e.state = (flushLeft > 0) ? 2'b01 : (drainLeft > 0) ? 2'b10 :
              inLoadStall ? 2'b11 : 2'b00;
    e.stall_cnt = modelCnt;
    if (s.ex_redirect) begin
      e.flush_id = 1; e.flush_ex = 1;
      flushLeft = FLUSH_N - 1; drainLeft = 0; inLoadStall = 0; csrOk = 0;
    end else if (flushLeft > 0) begin
      e.flush_id = 1; e.flush_ex = 1;
      flushLeft--;
    end else if (drainLeft > 0) begin
      e.stall_if = 1; e.stall_id = 1; e.flush_ex = 1;
      drainLeft--;
      if (drainLeft == 0) csrOk = 1;
    end else if (lu) begin
      e.stall_if = 1; e.stall_id = 1; e.flush_ex = 1;
      inLoadStall = 1;
    end else if (s.id_csr && !csrOk && anyWrite) begin
      e.stall_if = 1; e.stall_id = 1; e.flush_ex = 1;
      inLoadStall = 0;
      drainLeft = DRAIN_N - 1;
      if (drainLeft == 0) csrOk = 1;
    end else begin
      inLoadStall = 0; csrOk = 0;
    end
    if (e.stall_id) modelCnt = modelCnt + 1;
  endtask

  // Drive one cycle of inputs just after the rising edge and log the expectation
  task automatic applyStimulus(input stim_t s, input bit doReset);
    exp_t e;
    @(posedge clk); #1;
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
    id_use_rs1 = s.id_use_rs1; id_use_rs2 = s.id_use_rs2; id_csr = s.id_csr;
    ex_rd = s.ex_rd; ex_mem_read = s.ex_mem_read; ex_reg_write = s.ex_reg_write;
    mem_rd = s.mem_rd; mem_reg_write = s.mem_reg_write;
    wb_rd = s.wb_rd; wb_reg_write = s.wb_reg_write;
    ex_redirect = s.ex_redirect;
    reset = doReset;
    if (doReset) begin
      e = '0;
      flushLeft = 0; drainLeft = 0; inLoadStall = 0; csrOk = 0; modelCnt = '0;
    end else begin
      modelStep(s, e);
    end
    expQ.push_back(e);
  endtask

  task automatic checkField(input string name, input logic [CW-1:0] act,
                            input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("stall_if", CW'(stall_if), CW'(e.stall_if));
    checkField("stall_id", CW'(stall_id), CW'(e.stall_id));
    checkField("flush_id", CW'(flush_id), CW'(e.flush_id));
    checkField("flush_ex", CW'(flush_ex), CW'(e.flush_ex));
    checkField("fwd_a", CW'(fwd_a), CW'(e.fwd_a));
    checkField("fwd_b", CW'(fwd_b), CW'(e.fwd_b));
    checkField("state", CW'(state), CW'(e.state));
    checkField("stall_cnt", stall_cnt, e.stall_cnt);
  endtask

  // Monitor: compare mid-cycle, away from the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    stim_t s;
    int waitCycles;

    $display("[TB] reset check");
    applyStimulus(idleStim(), 1);
    applyStimulus(idleStim(), 1);

    $display("[TB] load-use");
    s = idleStim();
    s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_rd = 5;
    s.id_use_rs1 = 1; s.id_rs1 = 5;
    applyStimulus(s, 0);
    s.ex_mem_read = 0; s.ex_reg_write = 0;
    applyStimulus(s, 0);
    applyStimulus(idleStim(), 0);

    $display("[TB] redirect single and extended");
    s = idleStim(); s.ex_redirect = 1;
    applyStimulus(s, 0);
    repeat (3) applyStimulus(idleStim(), 0);
    applyStimulus(s, 0);
    applyStimulus(s, 0);
    repeat (3) applyStimulus(idleStim(), 0);

    $display("[TB] CSR drain and zero-penalty CSR");
    s = idleStim(); s.id_csr = 1; s.mem_reg_write = 1; s.mem_rd = 3;
    repeat (5) applyStimulus(s, 0);
    s.mem_reg_write = 0;
    repeat (2) applyStimulus(s, 0);
    applyStimulus(idleStim(), 0);

    $display("[TB] priority: lu with redirect, redirect mid-drain");
    s = idleStim();
    s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_rd = 2;
    s.id_use_rs2 = 1; s.id_rs2 = 2; s.ex_redirect = 1;
    applyStimulus(s, 0);
    applyStimulus(idleStim(), 0);
    applyStimulus(idleStim(), 0);
    s = idleStim(); s.id_csr = 1; s.wb_reg_write = 1; s.wb_rd = 4;
    applyStimulus(s, 0);
    applyStimulus(s, 0);
    s.ex_redirect = 1;
    applyStimulus(s, 0);
    s.ex_redirect = 0;
    repeat (6) applyStimulus(s, 0);

    $display("[TB] forwarding");
    s = idleStim();
    s.mem_reg_write = 1; s.wb_reg_write = 1; s.mem_rd = 7; s.wb_rd = 7; s.id_rs1 = 7;
    applyStimulus(s, 0);
    s = idleStim(); s.mem_reg_write = 1; s.id_rs1 = 0;
    applyStimulus(s, 0);
    s = idleStim(); s.wb_reg_write = 1; s.wb_rd = 9; s.id_rs2 = 9;
    applyStimulus(s, 0);

    $display("[TB] reset mid-drain");
    s = idleStim(); s.id_csr = 1; s.ex_reg_write = 1; s.ex_rd = 1;
    applyStimulus(s, 0);
    applyStimulus(s, 0);
    applyStimulus(s, 1);
    applyStimulus(idleStim(), 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(randStim(), ($urandom_range(0, 199) == 0));
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
